// File: rtl/i2c_slave_regfile_if.sv
// Register-bus bundle between the I2C target and the register file it fronts.
// The I2C side is the master: it issues write strobes and the read address; the file returns read data.
interface i2c_slave_regfile_if #(
   parameter int REG_AW = 8
);
   logic              o_wr_en;
   logic [REG_AW-1:0] o_wr_addr;
   logic [7:0]        o_wr_data;
   logic [REG_AW-1:0] o_rd_addr;
   logic [7:0]        i_rd_data;

   modport master (
      output o_wr_en, o_wr_addr, o_wr_data, o_rd_addr,
      input  i_rd_data
   );

   modport slave (
      input  o_wr_en, o_wr_addr, o_wr_data, o_rd_addr,
      output i_rd_data
   );
endinterface

// File: rtl/i2c_slave_regfile.sv
// Oversampled I2C target with pointer/auto-increment register back end; pin-to-event latency SYNC_STAGES+1 cycles.
// No backpressure: register writes are fire-and-forget strobes, read data must be valid combinationally.
module i2c_slave_regfile #(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         REG_AW      = 8,
   parameter int         SYNC_STAGES = 2,
   parameter int         AUTO_INC    = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_scl,
   inout  wire                  io_sda,
   i2c_slave_regfile_if.master  reg_bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_nack_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_WAIT_STOP
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic [7:0]             shift_q;
   logic [3:0]             bit_cnt_q;
   logic [REG_AW-1:0]      ptr_q;
   logic                   rw_q, matched_q, sda_oe_q;
   logic                   wr_en_q, busy_q, done_q, nack_err_q;
   logic [REG_AW-1:0]      wr_addr_q;
   logic [7:0]             wr_data_q;

   logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;

   assign io_sda = sda_oe_q ? 1'b0 : 1'bz;

   assign reg_bus.o_wr_en   = wr_en_q;
   assign reg_bus.o_wr_addr = wr_addr_q;
   assign reg_bus.o_wr_data = wr_data_q;
   assign reg_bus.o_rd_addr = ptr_q;
   assign o_busy            = busy_q;
   assign o_done            = done_q;
   assign o_nack_err        = nack_err_q;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

   // Synchronisers preset to the idle-high bus level so reset release cannot fake an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], io_sda};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 4'd0;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         matched_q  <= 1'b0;
         sda_oe_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         nack_err_q <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         // Bus conditions win over any bit edge seen in the same cycle.
         if (start_ev) begin
            state_q    <= S_ADDR;
            bit_cnt_q  <= 4'd0;
            sda_oe_q   <= 1'b0;
            nack_err_q <= 1'b0;
         end else if (stop_ev) begin
            if (state_q == S_RDATA) nack_err_q <= 1'b1;
            done_q    <= matched_q;
            matched_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
         end else begin
            case (state_q)
               S_ADDR, S_PTR, S_WDATA: begin
                  if (scl_rise && bit_cnt_q != 4'd8) begin
                     shift_q   <= {shift_q[6:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall && bit_cnt_q == 4'd8) begin
                     bit_cnt_q <= 4'd0;
                     if (state_q == S_ADDR) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                           rw_q      <= shift_q[0];
                           matched_q <= 1'b1;
                           busy_q    <= 1'b1;
                           sda_oe_q  <= 1'b1;
                           state_q   <= S_ADDR_ACK;
                        end else begin
                           busy_q  <= 1'b0;
                           state_q <= S_WAIT_STOP;
                        end
                     end else if (state_q == S_PTR) begin
                        ptr_q    <= REG_AW'(shift_q);
                        sda_oe_q <= 1'b1;
                        state_q  <= S_PTR_ACK;
                     end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= shift_q;
                        if (AUTO_INC != 0) ptr_q <= ptr_q + REG_AW'(1);
                        sda_oe_q  <= 1'b1;
                        state_q   <= S_WDATA_ACK;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (rw_q) begin
                        shift_q   <= reg_bus.i_rd_data;
                        sda_oe_q  <= ~reg_bus.i_rd_data[7];
                        bit_cnt_q <= 4'd1;
                        state_q   <= S_RDATA;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= S_PTR;
                     end
                  end
               end
               S_PTR_ACK, S_WDATA_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q  <= 1'b0;
                     bit_cnt_q <= 4'd0;
                     state_q   <= S_WDATA;
                  end
               end
               S_RDATA: begin
                  if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= S_MACK;
                     end else begin
                        sda_oe_q  <= ~shift_q[6];
                        shift_q   <= {shift_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
               end
               S_MACK: begin
                  // Pointer moves at the ACK sample so rd_data for the next byte is ready by the fall.
                  if (scl_rise) begin
                     if (sda_s) begin
                        busy_q  <= 1'b0;
                        state_q <= S_WAIT_STOP;
                     end else if (AUTO_INC != 0) begin
                        ptr_q <= ptr_q + REG_AW'(1);
                     end
                  end else if (scl_fall) begin
                     shift_q   <= reg_bus.i_rd_data;
                     sda_oe_q  <= ~reg_bus.i_rd_data[7];
                     bit_cnt_q <= 4'd1;
                     state_q   <= S_RDATA;
                  end
               end
               default: begin
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench: table of write transactions plus hand-written read, abort and reset sequences.
module tb_i2c_slave_regfile;
   localparam int Q = 80;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl = 1'b1;
   logic m_sda_low = 1'b0;
   wire  sda;
   logic busy, done, nack_err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int low_cnt = 0;
   int busy_cnt = 0;
   logic [15:0] wr_log[$];

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   i2c_slave_regfile_if #(.REG_AW(8)) bus ();
   assign bus.i_rd_data = ~bus.o_rd_addr;

   i2c_slave_regfile dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_scl      (scl),
      .io_sda     (sda),
      .reg_bus    (bus),
      .o_busy     (busy),
      .o_done     (done),
      .o_nack_err (nack_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_wr_en) wr_log.push_back({bus.o_wr_addr, bus.o_wr_data});
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (sda === 1'b0 && !m_sda_low) low_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; #Q;
      scl = 1'b1;       #Q;
      m_sda_low = 1'b1; #Q;
      scl = 1'b0;       #Q;
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; #Q;
      scl = 1'b1;       #Q;
      m_sda_low = 1'b0; #Q;
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b; #Q;
      scl = 1'b1;     #(2*Q);
      scl = 1'b0;     #Q;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      m_sda_low = 1'b0; #Q;
      scl = 1'b1;       #Q;
      ack = (sda === 1'b0);
      #Q;
      scl = 1'b0;       #Q;
   endtask

   task automatic read_byte(input logic master_ack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         #Q; scl = 1'b1;
         #Q; d[i] = sda;
         #Q; scl = 1'b0;
      end
      #Q; m_sda_low = master_ack;
      #Q; scl = 1'b1;
      #(2*Q); scl = 1'b0;
      #Q; m_sda_low = 1'b0;
   endtask

   typedef struct {
      logic [7:0]      addr_byte;
      logic [7:0]      ptr;
      int              n;
      logic [2:0][7:0] dat;
      logic            exp_ack;
      int              exp_wr;
      logic [2:0][7:0] exp_addr;
      int              exp_done;
      logic [7:0]      exp_ptr;
   } wvec_t;

   wvec_t vec[4];

   initial begin
      logic       ack;
      logic [7:0] rd;
      int wb, db, lb, bb;

      vec[0] = '{8'hA0, 8'h10, 3, {8'h33, 8'h22, 8'h11}, 1'b1, 3, {8'h12, 8'h11, 8'h10}, 1, 8'h13};
      vec[1] = '{8'hA0, 8'hFF, 2, {8'h00, 8'hA5, 8'h5A}, 1'b1, 2, {8'h00, 8'h00, 8'hFF}, 1, 8'h01};
      vec[2] = '{8'hA2, 8'h10, 2, {8'h00, 8'h88, 8'h77}, 1'b0, 0, {8'h00, 8'h00, 8'h00}, 0, 8'h01};
      vec[3] = '{8'hA0, 8'h7F, 1, {8'h00, 8'h00, 8'hC3}, 1'b1, 1, {8'h00, 8'h00, 8'h7F}, 1, 8'h80};

      #20;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_nack_err", nack_err, 0);
      check("reset_wr_en", bus.o_wr_en, 0);
      check("reset_rd_addr", bus.o_rd_addr, 0);
      check("reset_sda", sda, 1);
      rst_n = 1'b1;
      #(2*Q);

      for (int v = 0; v < 4; v++) begin
         wb = wr_log.size(); db = done_cnt; lb = low_cnt; bb = busy_cnt;
         i2c_start();
         write_byte(vec[v].addr_byte, ack);
         check($sformatf("v%0d_addr_ack", v), ack, vec[v].exp_ack);
         write_byte(vec[v].ptr, ack);
         check($sformatf("v%0d_ptr_ack", v), ack, vec[v].exp_ack);
         for (int i = 0; i < vec[v].n; i++) begin
            write_byte(vec[v].dat[i], ack);
            check($sformatf("v%0d_data%0d_ack", v, i), ack, vec[v].exp_ack);
         end
         i2c_stop();
         #(4*Q);
         check($sformatf("v%0d_wr_count", v), wr_log.size() - wb, vec[v].exp_wr);
         for (int i = 0; i < vec[v].exp_wr; i++) begin
            if (wb + i < wr_log.size()) begin
               check($sformatf("v%0d_wr%0d_addr", v, i), wr_log[wb+i][15:8], vec[v].exp_addr[i]);
               check($sformatf("v%0d_wr%0d_data", v, i), wr_log[wb+i][7:0], vec[v].dat[i]);
            end
         end
         check($sformatf("v%0d_done_count", v), done_cnt - db, vec[v].exp_done);
         check($sformatf("v%0d_busy_seen", v), busy_cnt != bb, vec[v].exp_ack);
         check($sformatf("v%0d_sda_low_seen", v), low_cnt != lb, vec[v].exp_ack);
         check($sformatf("v%0d_busy_after_stop", v), busy, 0);
         check($sformatf("v%0d_ptr", v), bus.o_rd_addr, vec[v].exp_ptr);
      end

      // Pointer set by a write, then repeated START into a two-byte read.
      wb = wr_log.size(); db = done_cnt;
      i2c_start();
      write_byte(8'hA0, ack); check("rd_addr_w_ack", ack, 1);
      write_byte(8'h05, ack); check("rd_ptr_ack", ack, 1);
      i2c_start();
      write_byte(8'hA1, ack); check("rd_addr_r_ack", ack, 1);
      read_byte(1'b1, rd);    check("rd_byte0", rd, 8'hFA);
      read_byte(1'b0, rd);    check("rd_byte1", rd, 8'hF9);
      check("rd_busy_after_nack", busy, 0);
      i2c_stop();
      #(4*Q);
      check("rd_nack_err", nack_err, 0);
      check("rd_done_count", done_cnt - db, 1);
      check("rd_no_writes", wr_log.size() - wb, 0);
      check("rd_ptr_final", bus.o_rd_addr, 8'h06);

      // STOP four bits into a data byte drops it; the following write is intact.
      wb = wr_log.size();
      i2c_start();
      write_byte(8'hA0, ack); check("ab_addr_ack", ack, 1);
      write_byte(8'h20, ack); check("ab_ptr_ack", ack, 1);
      for (int i = 0; i < 4; i++) write_bit(i[0]);
      i2c_stop();
      #(4*Q);
      check("ab_no_write", wr_log.size() - wb, 0);
      check("ab_busy", busy, 0);
      i2c_start();
      write_byte(8'hA0, ack); check("ab2_addr_ack", ack, 1);
      write_byte(8'h20, ack); check("ab2_ptr_ack", ack, 1);
      write_byte(8'h44, ack); check("ab2_data_ack", ack, 1);
      i2c_stop();
      #(4*Q);
      check("ab2_wr_count", wr_log.size() - wb, 1);
      if (wr_log.size() > wb) check("ab2_wr", wr_log[wb], 16'h2044);

      // Reset while the target is driving a 0 data bit (rd_data of 0x80 is 0x7F).
      i2c_start();
      write_byte(8'hA0, ack); check("rst_addr_w_ack", ack, 1);
      write_byte(8'h80, ack); check("rst_ptr_ack", ack, 1);
      i2c_start();
      write_byte(8'hA1, ack); check("rst_addr_r_ack", ack, 1);
      check("rst_sda_driven", sda, 0);
      check("rst_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst_sda_released", sda, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_nack_err", nack_err, 0);
      check("rst_wr_en", bus.o_wr_en, 0);
      check("rst_ptr", bus.o_rd_addr, 0);
      scl = 1'b1;
      #Q;
      rst_n = 1'b1;
      #(2*Q);
      check("rst_after_sda", sda, 1);
      check("rst_after_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
